// File: rtl/serial_link.sv
// serial_link: transfer engine behind the SB (serial data) and SC (serial
// control) registers. While SC[7] is set it shifts SB out MSB-first on sout
// and shifts sin into SB LSB-first, eight bits per transfer. It then clears
// SC[7] and pulses serial_int.
//
// The block does not own SB/SC. It sees their current values (sb_q, sc_q)
// and returns their next values (sb_d, sc_d).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   sb_q / sb_d       current / next SB value
//   sc_q / sc_d       current / next SC value
//                     (bit 7 = start/busy, bit 0 = 1 internal clock)
//   serial_int        one-cycle interrupt request on completion
//   busy              high while a transfer is in progress
//   sclk_in           external link clock (asynchronous)
//   sclk_out, sclk_oe internal link clock (idles high) and its drive enable
//   sin               link serial input (asynchronous)
//   sout              link serial output (idles high)
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no transfer; link outputs parked high, sclk not driven
// INT_LOW  | internal clock low half; last cycle is the shift cycle
// INT_HIGH | internal clock high half; at its end the next bit goes out
// EXT_WAIT | external clock mode; edges of synchronised sclk_in act
module serial_link #(
  parameter int CLK_DIV     = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sb_q,
  input  logic [7:0] sc_q,
  output logic [7:0] sb_d,
  output logic [7:0] sc_d,
  output logic       serial_int,
  output logic       busy,
  input  logic       sclk_in,
  output logic       sclk_out,
  output logic       sclk_oe,
  input  logic       sin,
  output logic       sout
);

  localparam int H  = CLK_DIV / 2;
  localparam int TW = $clog2(H);
  localparam logic [TW-1:0] HALF_LOAD = TW'(H - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_LOW  = 2'd1,
    INT_HIGH = 2'd2,
    EXT_WAIT = 2'd3
  } state_t;

  state_t                 state, state_nx;
  logic [TW-1:0]          timer, timer_nx;
  logic [2:0]             bit_cnt, bit_cnt_nx;
  logic                   done, done_nx;
  logic                   sclk_out_nx, sclk_oe_nx, sout_nx;
  logic                   shift, abort;

  logic [SYNC_STAGES-1:0] sclk_sync, sin_sync;
  logic                   sclk_s, sin_s, sclk_prev;
  logic                   sclk_rise, sclk_fall;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign sin_s  = sin_sync[SYNC_STAGES-1];
  assign busy   = (state != IDLE);

  // Synchronisers are preset high so that reset release does not look
  // like a falling edge on an idle (high) link. The edge pulses are
  // registered, which puts a pin edge SYNC_STAGES+1 cycles ahead of the
  // cycle that acts on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      sin_sync  <= '1;
      sclk_prev <= 1'b1;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      sin_sync  <= {sin_sync[SYNC_STAGES-2:0], sin};
      sclk_prev <= sclk_s;
      sclk_rise <= sclk_s & ~sclk_prev;
      sclk_fall <= ~sclk_s & sclk_prev;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      done     <= 1'b0;
      sclk_out <= 1'b1;
      sclk_oe  <= 1'b0;
      sout     <= 1'b1;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      bit_cnt  <= bit_cnt_nx;
      done     <= done_nx;
      sclk_out <= sclk_out_nx;
      sclk_oe  <= sclk_oe_nx;
      sout     <= sout_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    bit_cnt_nx  = bit_cnt;
    done_nx     = done;
    sclk_out_nx = sclk_out;
    sclk_oe_nx  = sclk_oe;
    sout_nx     = sout;
    sb_d        = sb_q;
    sc_d        = sc_q;
    serial_int  = 1'b0;
    shift       = 1'b0;

    // Dropping SC[7] mid-transfer wins over any shift or completion.
    abort = (state != IDLE) && !sc_q[7];

    unique case (state)
      IDLE: begin
        // The clock source is captured in the choice of next state, so
        // later writes to SC[0] cannot disturb a running transfer.
        if (sc_q[7]) begin
          bit_cnt_nx = '0;
          done_nx    = 1'b0;
          timer_nx   = HALF_LOAD;
          if (sc_q[0]) begin
            state_nx    = INT_LOW;
            sclk_out_nx = 1'b0;
            sclk_oe_nx  = 1'b1;
            sout_nx     = sb_q[7];
          end else begin
            state_nx = EXT_WAIT;
          end
        end
      end
      INT_LOW: begin
        if (timer == '0) begin
          shift       = 1'b1;
          state_nx    = INT_HIGH;
          timer_nx    = HALF_LOAD;
          sclk_out_nx = 1'b1;
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      INT_HIGH: begin
        if (timer == '0) begin
          state_nx    = INT_LOW;
          timer_nx    = HALF_LOAD;
          sclk_out_nx = 1'b0;
          sout_nx     = sb_q[7];
        end else begin
          timer_nx = timer - 1'b1;
        end
      end
      EXT_WAIT: begin
        if (sclk_fall) sout_nx = sb_q[7];
        if (sclk_rise) shift = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    if (abort) begin
      state_nx = IDLE;
    end else if (shift && !done) begin
      sb_d       = {sb_q[6:0], sin_s};
      bit_cnt_nx = bit_cnt + 3'd1;
      // The eighth shift completes the transfer; the done flag keeps the
      // 3-bit counter from being reused as a ninth bit.
      if (bit_cnt == 3'd7) begin
        done_nx    = 1'b1;
        sc_d       = {1'b0, sc_q[6:0]};
        serial_int = 1'b1;
        state_nx   = IDLE;
      end
    end

    if (state != IDLE && state_nx == IDLE) begin
      sclk_out_nx = 1'b1;
      sclk_oe_nx  = 1'b0;
      sout_nx     = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_link.sv
// Bench for serial_link with CLK_DIV = 8 (H = 4) and two synchroniser stages.
// The bench owns the SB/SC registers and loads them from sb_d/sc_d every
// clock unless it is writing them itself. Internal transfers are predicted
// per cycle from the bit-timing rules: shift k occurs at T+(2k-1)*H.
module tb_serial_link;

  localparam int CLK_DIV = 8;
  localparam int H       = CLK_DIV / 2;
  localparam int T_DONE  = 15 * H;

  logic       clk, rst_n;
  logic [7:0] sb_q, sc_q, sb_d, sc_d;
  logic       serial_int, busy, sclk_in, sclk_out, sclk_oe, sin, sout;

  logic       wr_sb_en, wr_sc_en;
  logic [7:0] wr_sb, wr_sc;
  logic       sin_drv, loop_en;

  int n_checks = 0;
  int n_fail   = 0;

  serial_link #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sb_q       (sb_q),
    .sc_q       (sc_q),
    .sb_d       (sb_d),
    .sc_d       (sc_d),
    .serial_int (serial_int),
    .busy       (busy),
    .sclk_in    (sclk_in),
    .sclk_out   (sclk_out),
    .sclk_oe    (sclk_oe),
    .sin        (sin),
    .sout       (sout)
  );

  assign sin = loop_en ? sout : sin_drv;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= 8'h00;
      sc_q <= 8'h00;
    end else begin
      sb_q <= wr_sb_en ? wr_sb : sb_d;
      sc_q <= wr_sc_en ? wr_sc : sc_d;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] sb;
    logic [7:0] rbits;
    int         abort_d;
    bit         loop;
    logic [7:0] exp_sb;
    int         exp_ints;
  } vec_t;

  // Internal transfer: writes SB=s, SC=0x81 so that cycle d=0 is the start
  // cycle T. rbits supplies the sin bits, first-shifted bit at rbits[7].
  // abort_d in 1..15H clears SC[7] for cycle abort_d.
  task automatic run_internal(input logic [7:0] s, input logic [7:0] r, input int abort_d,
                              input bit loop, output logic [7:0] fin_sb, output int ints);
    logic [7:0] rr;
    bit         ab, act;
    int         e, nsh, j, j1, t;
    logic [7:0] exp_sb, exp_sc;
    logic       exp_clk, exp_sout, exp_int;
    rr = loop ? s : r;
    ab = (abort_d >= 1) && (abort_d <= T_DONE);
    e  = ab ? abort_d : T_DONE;
    ints = 0;
    loop_en = loop;
    @(negedge clk);
    wr_sb = s; wr_sc = 8'h81; wr_sb_en = 1'b1; wr_sc_en = 1'b1;
    sin_drv = rr[7];
    @(negedge clk);
    wr_sb_en = 1'b0; wr_sc_en = 1'b0;
    for (int d = 0; d <= e + 3; d++) begin
      act = (d >= 1) && (d <= e);
      exp_int = !ab && (d == T_DONE);
      exp_clk = act ? 1'(((d - 1) / H) % 2) : 1'b1;
      j = act ? (d - 1) / (2 * H) : 0;
      exp_sout = act ? s[7 - j] : 1'b1;
      nsh = 0;
      for (int k = 1; k <= 8; k++) begin
        t = (2 * k - 1) * H;
        if (t < d && (!ab || t < abort_d)) nsh++;
      end
      exp_sb = 8'(((32'(s) << nsh) | (32'(rr) >> (8 - nsh))) & 255);
      if (ab) exp_sc = (d < abort_d) ? 8'h81 : 8'h01;
      else    exp_sc = (d <= T_DONE) ? 8'h81 : 8'h01;
      check($sformatf("busy d=%0d", d), 32'(busy), 32'(act));
      check($sformatf("sclk_oe d=%0d", d), 32'(sclk_oe), 32'(act));
      check($sformatf("sclk_out d=%0d", d), 32'(sclk_out), 32'(exp_clk));
      check($sformatf("sout d=%0d", d), 32'(sout), 32'(exp_sout));
      check($sformatf("serial_int d=%0d", d), 32'(serial_int), 32'(exp_int));
      check($sformatf("sb d=%0d", d), 32'(sb_q), 32'(exp_sb));
      check($sformatf("sc d=%0d", d), 32'(sc_q), 32'(exp_sc));
      if (serial_int) ints++;
      j1 = d / (2 * H);
      if (j1 < 8) sin_drv = rr[7 - j1];
      else        sin_drv = 1'b1;
      if (ab && (d + 1 == abort_d)) begin
        wr_sc = 8'h01; wr_sc_en = 1'b1;
      end else begin
        wr_sc_en = 1'b0;
      end
      @(negedge clk);
    end
    wr_sc_en = 1'b0;
    fin_sb = sb_q;
    loop_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[5];
    logic [7:0] fin, s, r, sbv, sb_prev;
    int         ints, ab;

    vecs[0] = '{8'hA5, 8'hFF, 0,         1'b0, 8'hFF, 1};
    vecs[1] = '{8'h3C, 8'h00, 0,         1'b1, 8'h3C, 1};
    vecs[2] = '{8'hA5, 8'hFF, 5 * H + 1, 1'b0, 8'h2F, 0};
    vecs[3] = '{8'h5A, 8'hFF, T_DONE,    1'b0, 8'h7F, 0};
    vecs[4] = '{8'hC3, 8'h96, 0,         1'b0, 8'h96, 1};

    rst_n = 1'b0; sclk_in = 1'b1; sin_drv = 1'b1; loop_en = 1'b0;
    wr_sb_en = 1'b0; wr_sc_en = 1'b0; wr_sb = 8'h00; wr_sc = 8'h00;
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst sclk_out", 32'(sclk_out), 32'd1);
    check("rst sclk_oe", 32'(sclk_oe), 32'd0);
    check("rst sout", 32'(sout), 32'd1);
    check("rst serial_int", 32'(serial_int), 32'd0);
    check("rst sc_d", 32'(sc_d), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_internal(vecs[i].sb, vecs[i].rbits, vecs[i].abort_d, vecs[i].loop, fin, ints);
      check($sformatf("vec%0d final sb", i), 32'(fin), 32'(vecs[i].exp_sb));
      check($sformatf("vec%0d int count", i), 32'(ints), 32'(vecs[i].exp_ints));
      repeat (2) @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      s  = 8'($urandom_range(0, 255));
      r  = 8'($urandom_range(0, 255));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, T_DONE)) : 0;
      run_internal(s, r, ab, 1'b0, fin, ints);
      repeat (2) @(negedge clk);
    end

    // External clock transfer: 8 pin pulses, 10 cycles low then 10 high.
    @(negedge clk);
    wr_sb = 8'h0F; wr_sc = 8'h80; wr_sb_en = 1'b1; wr_sc_en = 1'b1;
    @(negedge clk);
    wr_sb_en = 1'b0; wr_sc_en = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      sin_drv = (p <= 4);
      sclk_in = 1'b0;
      repeat (10) @(negedge clk);
      sb_prev = 8'(((32'h0F << (p - 1)) | (32'hF0 >> (9 - p))) & 255);
      check($sformatf("ext sout p%0d", p), 32'(sout), 32'(sb_prev[7]));
      check($sformatf("ext sclk_oe p%0d", p), 32'(sclk_oe), 32'd0);
      check($sformatf("ext busy p%0d", p), 32'(busy), 32'd1);
      sclk_in = 1'b1;
      repeat (2) @(negedge clk);
      check($sformatf("ext early int p%0d", p), 32'(serial_int), 32'd0);
      @(negedge clk);
      check($sformatf("ext int p%0d", p), 32'(serial_int), 32'(p == 8));
      @(negedge clk);
      sbv = 8'(((32'h0F << p) | (32'hF0 >> (8 - p))) & 255);
      check($sformatf("ext sb p%0d", p), 32'(sb_q), 32'(sbv));
      check($sformatf("ext busy after p%0d", p), 32'(busy), 32'(p < 8));
      repeat (6) @(negedge clk);
    end
    check("ext final sc", 32'(sc_q), 32'h00);
    check("ext final sclk_oe", 32'(sclk_oe), 32'd0);
    check("ext final sout", 32'(sout), 32'd1);

    // Reset in the middle of the 5th bit of an internal transfer.
    @(negedge clk);
    wr_sb = 8'hA5; wr_sc = 8'h81; wr_sb_en = 1'b1; wr_sc_en = 1'b1;
    @(negedge clk);
    wr_sb_en = 1'b0; wr_sc_en = 1'b0;
    repeat (9 * H) @(negedge clk);
    check("pre-rst busy", 32'(busy), 32'd1);
    check("pre-rst sclk_out", 32'(sclk_out), 32'd0);
    check("pre-rst sout", 32'(sout), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst sclk_out", 32'(sclk_out), 32'd1);
    check("mid rst sclk_oe", 32'(sclk_oe), 32'd0);
    check("mid rst sout", 32'(sout), 32'd1);
    check("mid rst serial_int", 32'(serial_int), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check($sformatf("post-rst busy c%0d", c), 32'(busy), 32'd0);
      check($sformatf("post-rst sclk_oe c%0d", c), 32'(sclk_oe), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_link.md
Name: serial_link

Overview:
- Transfer engine behind the serial data (SB) and serial control (SC) control registers.
- While SC[7] is set, shifts SB out MSB-first on the link output and shifts link-input bits into SB LSB-first, eight bits per transfer.
- On completion it clears SC[7] and raises the serial interrupt.
- Sits beside the timer/joypad next-state logic in top: it consumes the current register values and produces their next values plus the serial_int request.

Parameters:
- CLK_DIV, 512, system clocks per internal serial bit (8192 Hz at 4.194304 MHz); must be even and at least 4; H = CLK_DIV/2.
- SYNC_STAGES, 2, synchroniser depth on sclk_in and sin; at least 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- sb_q  input  8  current SB register value.
- sc_q  input  8  current SC register value; bit 7 = transfer start/busy, bit 0 = clock source (1 internal, 0 external).
- sb_d  output  8  next SB value; feeds regin.serial_data.
- sc_d  output  8  next SC value; feeds regin.serial_control.
- serial_int  output  1  one-cycle interrupt request; feeds interrupt_st[3].
- busy  output  1  high while a transfer is in progress.
- sclk_in  input  1  external link clock (asynchronous).
- sclk_out  output  1  internal link clock; idles high.
- sclk_oe  output  1  drive enable for sclk_out.
- sin  input  1  link serial input (asynchronous).
- sout  output  1  link serial output; idles high.

Behaviour:
- Reset, asynchronous and immediate, including mid-transfer:
  - State = IDLE, bit count = 0, sclk_out = 1, sclk_oe = 0, sout = 1, serial_int = 0, busy = 0.
  - Synchronisers are preset to 1.
- Default outputs: sb_d = sb_q and sc_d = sc_q in every cycle not listed below.
- States: IDLE, INT_LOW, INT_HIGH, EXT_WAIT.
- IDLE:
  - If sc_q[7] = 1 in cycle T, latch mode = sc_q[0] and clear the bit count.
  - If mode = 1, go to INT_LOW; otherwise go to EXT_WAIT.
  - busy = 1 from T+1.
- Internal clock mode (mode = 1):
  - sclk_oe = 1 and sclk_out = 0 from T+1, with sout = sb_q[7] sampled at T.
  - INT_LOW lasts H cycles. Its last cycle is the shift cycle: sb_d = {sb_q[6:0], sin_sync}, the bit count increments, and sclk_out rises on the next clock.
  - INT_HIGH lasts H cycles. At its end, sclk_out falls, sout takes the then-current sb_q[7], and the state returns to INT_LOW.
  - The k-th shift occurs at cycle T + (2k-1)*H. The 8th shift is at T + 15*H and is the completion cycle.
- External clock mode (mode = 0):
  - sclk_oe = 0 throughout.
  - A falling edge of synchronised sclk_in loads sout with sb_q[7].
  - A rising edge of synchronised sclk_in makes that cycle a shift cycle.
  - Pin edge to shift cycle latency = SYNC_STAGES + 1 cycles.
  - No timeout: the block waits indefinitely for external edges.
- Completion cycle (8th shift):
  - sc_d = {1'b0, sc_q[6:0]}, serial_int = 1 for exactly this cycle, and the state goes to IDLE.
  - In the following cycle busy = 0, sclk_out = 1, sclk_oe = 0, sout = 1.
- Abort:
  - If sc_q[7] = 0 in any non-IDLE cycle, return to IDLE next cycle.
  - No shift occurs in that cycle, no serial_int is raised, and SB keeps its partially shifted value.
  - Abort has priority over a coincident shift or completion.
- Changes to sc_q[0] mid-transfer are ignored because mode is latched at start.
- Restart: sc_q[7] still 1 in the cycle after completion starts a new transfer. Normally the cleared sc_d prevents this.
- Bit counter is 3 bits plus a done flag. It must not wrap into a 9th bit.

Test Plan:
- Internal transfer, CLK_DIV = 8: sb_q = 0xA5, sc_q = 0x81, sin = 1 -> sout bits 1,0,1,0,0,1,0,1 on falling edges; 8 sclk_out pulses of period 8; completion at T+60 with sb_d = 0xFF, sc_d = 0x01, serial_int high for 1 cycle.
- Loopback, sin tied to sout, sb_q = 0x3C, internal -> final SB = 0x3C; serial_int once.
- External transfer: sc_q = 0x80, sb_q = 0x0F; drive 8 sclk_in pulses of 20 cycles each, with sin = 1 on pulses 1-4 and 0 on pulses 5-8 -> sclk_oe = 0 throughout; final SB = 0xF0; serial_int 3 cycles after the 8th rising pin edge.
- Abort: internal transfer, clear sc_q[7] after the 3rd shift -> IDLE next cycle, no serial_int, sclk_out = 1, SB holds the 3-bit-shifted value.
- Reset mid-transfer: assert rst_n = 0 at the 5th bit -> all outputs take reset values immediately; after release with sc_q = 0x00, the block stays IDLE.
- Coincident abort and completion: sc_q[7] = 0 in the 8th shift cycle -> no serial_int, sc_d = sc_q.
